// File: rtl/axis_fifo_pkt_pkg.sv
// Shared definitions for the packet FIFO: write-side state encoding,
// integer log2 for pointer sizing and the memory entry width.
// Contents: wr_state_t, log2(), entry_width().
package axis_fifo_pkt_pkg;

    typedef enum logic {
        ST_ACCEPT  = 1'b0,
        ST_DISCARD = 1'b1
    } wr_state_t;

    // Ceiling log2; depths are powers of two so this is exact in practice.
    function automatic int log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Each entry stores {tuser, tlast, tdata}.
    function automatic int entry_width(input int data_width, input int user_width);
        return data_width + user_width + 1;
    endfunction

endpackage

// File: rtl/axis_fifo_pkt_if.sv
// AXI-stream bundle used on both sides of the packet FIFO.
// Signals: tvalid, tready, tdata[DATA_WIDTH], tuser[USER_WIDTH], tlast.
// Modports: master drives the payload, slave drives tready.
interface axis_fifo_pkt_if #(
    parameter int DATA_WIDTH = 8,
    parameter int USER_WIDTH = 1
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic [USER_WIDTH-1:0] tuser;
    logic                  tlast;

    modport master (output tvalid, tdata, tuser, tlast, input tready);
    modport slave  (input tvalid, tdata, tuser, tlast, output tready);
endinterface

// File: rtl/axis_fifo_pkt_ram_sdp.sv
// Simple dual-port RAM: one write port, one registered read port, common
// clock enable. The read register is cleared by rst because it doubles as
// the FIFO's output data register.
// Ports: clk, rst, ena, we/wr_addr/wr_data, re/rd_addr, rd_data.
module axis_fifo_pkt_ram_sdp #(
    parameter int WIDTH      = 10,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);
    logic [WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (ena && we) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst)            rd_data <= '0;
        else if (ena && re) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/axis_fifo_pkt.sv
// AXI-stream FIFO with tlast/tuser sideband, exact occupancy and watermarks.
// Optional store-and-forward build: define AXIS_FIFO_PKT_STORE_FWD_EN.
// Ports: clk, rst (sync, active-high), ena, s_axis (slave), m_axis (master,
// registered), level (entries in memory, output register excluded),
// full/empty watermarks, drop (one-cycle pulse per discarded packet).
//
// Write-side states (store-and-forward build only):
//   state      | meaning
//   ST_ACCEPT  | beats written at wr_ptr, committed on a good tlast
//   ST_DISCARD | oversize packet: beats accepted and thrown away up to tlast
module axis_fifo_pkt
    import axis_fifo_pkt_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int USER_WIDTH   = 1,
    parameter int FIFO_DEPTH   = 16,
    parameter int FULL_THRESH  = FIFO_DEPTH - 2,
    parameter int EMPTY_THRESH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ena,
    axis_fifo_pkt_if.slave           s_axis,
    axis_fifo_pkt_if.master          m_axis,
    output logic [log2(FIFO_DEPTH):0] level,
    output logic                     full,
    output logic                     empty,
    output logic                     drop
);
    localparam int AW = log2(FIFO_DEPTH);
    localparam int EW = entry_width(DATA_WIDTH, USER_WIDTH);

    logic [AW:0]   wr_ptr, rd_ptr, wr_commit, wr_ptr_inc;
    logic          mem_full, readable, s_accept, rd_en, we, m_valid;
    logic [EW-1:0] rd_data;

    assign wr_ptr_inc = wr_ptr + 1'b1;
    assign mem_full   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    // The read side only ever sees committed beats.
    assign readable   = (rd_ptr != wr_commit);
    assign s_accept   = ena && s_axis.tvalid && s_axis.tready;
    assign rd_en      = ena && readable && (!m_valid || m_axis.tready);

    assign level = wr_ptr - rd_ptr;
    assign full  = (int'(level) >= FULL_THRESH);
    assign empty = (int'(level) <= EMPTY_THRESH);

`ifdef AXIS_FIFO_PKT_STORE_FWD_EN
    wr_state_t wr_state;

    // Back-pressure only when the memory is full and holds a committed packet
    // the reader can drain; a full buffer of one uncommitted packet is
    // resolved by dropping it, so tready stays high.
    assign s_axis.tready = (wr_state == ST_DISCARD) || !mem_full || (wr_commit == rd_ptr);
    assign we = s_accept && (wr_state == ST_ACCEPT) && !mem_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            wr_commit <= '0;
            wr_state  <= ST_ACCEPT;
            drop      <= 1'b0;
        end else if (!ena) begin
            drop <= 1'b0;
        end else begin
            drop <= 1'b0;
            if (s_accept) begin
                case (wr_state)
                    ST_ACCEPT: begin
                        if (mem_full) begin
                            // Buffer already holds only this packet's beats.
                            wr_ptr <= wr_commit;
                            drop   <= 1'b1;
                            if (!s_axis.tlast) wr_state <= ST_DISCARD;
                        end else if (s_axis.tlast) begin
                            if (s_axis.tuser[0]) begin
                                wr_ptr <= wr_commit;
                                drop   <= 1'b1;
                            end else begin
                                wr_ptr    <= wr_ptr_inc;
                                wr_commit <= wr_ptr_inc;
                            end
                        end else if ((wr_ptr_inc[AW-1:0] == rd_ptr[AW-1:0]) &&
                                     (wr_ptr_inc[AW] != rd_ptr[AW]) &&
                                     (wr_commit == rd_ptr)) begin
                            // Packet alone would fill the buffer: it can never commit.
                            wr_ptr   <= wr_commit;
                            drop     <= 1'b1;
                            wr_state <= ST_DISCARD;
                        end else begin
                            wr_ptr <= wr_ptr_inc;
                        end
                    end
                    ST_DISCARD: begin
                        if (s_axis.tlast) wr_state <= ST_ACCEPT;
                    end
                    default: wr_state <= ST_ACCEPT;
                endcase
            end
        end
    end
`else
    assign wr_commit     = wr_ptr;
    assign drop          = 1'b0;
    assign s_axis.tready = !mem_full;
    assign we            = s_accept;

    always_ff @(posedge clk) begin
        if (rst)           wr_ptr <= '0;
        else if (s_accept) wr_ptr <= wr_ptr_inc;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr  <= '0;
            m_valid <= 1'b0;
        end else if (ena) begin
            if (rd_en) begin
                rd_ptr  <= rd_ptr + 1'b1;
                m_valid <= 1'b1;
            end else if (m_axis.tready) begin
                m_valid <= 1'b0;
            end
        end
    end

    // The RAM read register is the output data register.
    axis_fifo_pkt_ram_sdp #(
        .WIDTH      (EW),
        .ADDR_WIDTH (AW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .we      (we),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data ({s_axis.tuser, s_axis.tlast, s_axis.tdata}),
        .re      (rd_en),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (rd_data)
    );

    assign m_axis.tvalid = m_valid;
    assign {m_axis.tuser, m_axis.tlast, m_axis.tdata} = rd_data;
endmodule

// File: tb/tb_axis_fifo_pkt.sv
// Scoreboard bench for axis_fifo_pkt (default parameters). Inputs are driven
// 1 time unit after the rising edge; everything is sampled on the falling edge.
module tb_axis_fifo_pkt;
    localparam int DW    = 8;
    localparam int UW    = 1;
    localparam int DEPTH = 16;
    localparam int EW    = DW + UW + 1;
`ifdef AXIS_FIFO_PKT_STORE_FWD_EN
    localparam bit SF = 1'b1;
`else
    localparam bit SF = 1'b0;
`endif

    typedef logic [EW-1:0] beat_t;

    logic       clk, rst, ena;
    logic [4:0] level;
    logic       full, empty, drop;

    axis_fifo_pkt_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) s_if ();
    axis_fifo_pkt_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) m_if ();

    axis_fifo_pkt dut (
        .clk    (clk),
        .rst    (rst),
        .ena    (ena),
        .s_axis (s_if),
        .m_axis (m_if),
        .level  (level),
        .full   (full),
        .empty  (empty),
        .drop   (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    vectors = 0;
    int    miscompares = 0;
    beat_t exp_q[$];
    beat_t pkt_q[$];
    bit    model_discard = 1'b0;
    int    exp_drops = 0;
    int    seen_drops = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // Reference model: the stream FIFO forwards every accepted beat; the
    // store-and-forward build releases a packet only once its good tlast
    // arrives, and drops bad or buffer-sized packets.
    task automatic model_accept(input beat_t b);
        if (!SF) begin
            exp_q.push_back(b);
        end else if (model_discard) begin
            if (b[DW]) model_discard = 1'b0;
        end else begin
            pkt_q.push_back(b);
            if (b[DW]) begin
                if (b[DW+1]) exp_drops++;
                else foreach (pkt_q[i]) exp_q.push_back(pkt_q[i]);
                pkt_q.delete();
            end else if (pkt_q.size() >= DEPTH) begin
                exp_drops++;
                model_discard = 1'b1;
                pkt_q.delete();
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst && ena && s_if.tvalid && s_if.tready)
            model_accept({s_if.tuser, s_if.tlast, s_if.tdata});
    end

    // Monitor: compare every transferred output beat, count drop pulses and
    // check the output holds while stalled.
    bit    held = 1'b0;
    beat_t held_beat;
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("hold_valid", 32'(m_if.tvalid), 32'd1);
                check("hold_beat", 32'({m_if.tuser, m_if.tlast, m_if.tdata}), 32'(held_beat));
            end
            if (ena && m_if.tvalid && m_if.tready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL out_beat: unexpected beat 0x%0h, expected none", {m_if.tuser, m_if.tlast, m_if.tdata});
                end else begin
                    check("out_beat", 32'({m_if.tuser, m_if.tlast, m_if.tdata}), 32'(exp_q.pop_front()));
                end
            end
            held      = m_if.tvalid && !(ena && m_if.tready);
            held_beat = {m_if.tuser, m_if.tlast, m_if.tdata};
            if (drop) seen_drops++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic last, input logic user);
        int n;
        bit acc;
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        s_if.tlast  = last;
        s_if.tuser  = user;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = ena && s_if.tready;
            tick();
            n++;
        end
        s_if.tvalid = 1'b0;
        if (!acc) bound_fail("send_beat");
    endtask

    task automatic drain();
        int n;
        n = 0;
        m_if.tready = 1'b1;
        while ((exp_q.size() != 0 || m_if.tvalid) && n < 500) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0 || m_if.tvalid) bound_fail("drain");
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
        pkt_q.delete();
        model_discard = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int plen, pcnt;
        bit acc;
        rst = 1'b1; ena = 1'b1;
        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0; s_if.tuser = '0;
        m_if.tready = 1'b0;
        tick();
        do_reset();

        // Reset state
        @(negedge clk);
        check("rst_tvalid", 32'(m_if.tvalid), 32'd0);
        check("rst_tdata", 32'({m_if.tuser, m_if.tlast, m_if.tdata}), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_tready", 32'(s_if.tready), 32'd1);
        check("rst_drop", 32'(drop), 32'd0);
        tick();

        // Latency of a single-beat packet into an empty FIFO
        m_if.tready = 1'b1;
        s_if.tvalid = 1'b1; s_if.tdata = 8'h55; s_if.tlast = 1'b1; s_if.tuser = 1'b0;
        tick();
        s_if.tvalid = 1'b0;
        @(negedge clk);
        check("lat_edge_n", 32'(m_if.tvalid), 32'd0);
        @(negedge clk);
        check("lat_edge_n1", 32'(m_if.tvalid), 32'd1);
        drain();

        // Fill: with tready low one beat sits in the output register, so 17
        // beats leave the memory holding 16.
        m_if.tready = 1'b0;
        for (int i = 0; i < 17; i++) send_beat(8'(i), 1'b1, 1'b0);
        @(negedge clk);
        check("fill_tready", 32'(s_if.tready), 32'd0);
        check("fill_level", 32'(level), 32'd16);
        check("fill_full", 32'(full), 32'd1);
        check("fill_empty", 32'(empty), 32'd0);
        tick();
        drain();
        @(negedge clk);
        check("drain_level", 32'(level), 32'd0);
        check("drain_empty", 32'(empty), 32'd1);
        tick();

        // Steady push/pop at level 5
        m_if.tready = 1'b0;
        for (int i = 0; i < 6; i++) send_beat(8'(8'h20 + i), 1'b1, 1'b0);
        @(negedge clk);
        check("pp_level_start", 32'(level), 32'd5);
        tick();
        m_if.tready = 1'b1;
        s_if.tvalid = 1'b1; s_if.tlast = 1'b1; s_if.tuser = 1'b0;
        for (int i = 0; i < 100; i++) begin
            s_if.tdata = 8'(8'h40 + i);
            tick();
            @(negedge clk);
            check("pp_level", 32'(level), 32'd5);
        end
        tick();
        s_if.tvalid = 1'b0;
        drain();

        // ena low freezes everything
        m_if.tready = 1'b0;
        for (int i = 0; i < 3; i++) send_beat(8'(8'hE0 + i), 1'b1, 1'b0);
        ena = 1'b0;
        s_if.tvalid = 1'b1; s_if.tdata = 8'h99; m_if.tready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            check("ena_level", 32'(level), 32'd2);
            check("ena_drop", 32'(drop), 32'd0);
        end
        tick();
        s_if.tvalid = 1'b0;
        ena = 1'b1;
        drain();

        // Reset with a partial packet stored
        m_if.tready = 1'b0;
        for (int i = 0; i < 7; i++) send_beat(8'(8'h70 + i), 1'b0, 1'b0);
        do_reset();
        @(negedge clk);
        check("mrst_level", 32'(level), 32'd0);
        check("mrst_tvalid", 32'(m_if.tvalid), 32'd0);
        check("mrst_tready", 32'(s_if.tready), 32'd1);
        tick();
        m_if.tready = 1'b1;
        for (int i = 0; i < 3; i++) send_beat(8'(8'hC0 + i), 1'b1, 1'b0);
        drain();

`ifdef AXIS_FIFO_PKT_STORE_FWD_EN
        // 4-beat packet: nothing appears until its tlast is stored
        m_if.tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_beat(8'(8'h10 + i), 1'b0, 1'b0);
            @(negedge clk);
            check("sf_wait_valid", 32'(m_if.tvalid), 32'd0);
            tick();
        end
        s_if.tvalid = 1'b1; s_if.tdata = 8'h13; s_if.tlast = 1'b1; s_if.tuser = 1'b0;
        tick();
        s_if.tvalid = 1'b0;
        @(negedge clk);
        check("sf_lat_t", 32'(m_if.tvalid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("sf_burst_valid", 32'(m_if.tvalid), 32'd1);
            check("sf_burst_last", 32'(m_if.tlast), 32'(k == 3));
        end
        tick();
        drain();

        // Good packet A then bad packet B
        m_if.tready = 1'b0;
        for (int i = 0; i < 3; i++) send_beat(8'(8'hA0 + i), i == 2, 1'b0);
        for (int i = 0; i < 3; i++) send_beat(8'(8'hB0 + i), i == 2, i == 2);
        @(negedge clk);
        check("bad_drop", 32'(drop), 32'd1);
        // A's first beat already sits in the output register.
        check("bad_level", 32'(level), 32'd2);
        @(negedge clk);
        check("bad_drop_pulse", 32'(drop), 32'd0);
        tick();
        drain();

        // Oversize packet is dropped at beat 16, the rest discarded
        for (int i = 0; i < 20; i++) begin
            send_beat(8'(8'h80 + i), i == 19, 1'b0);
            if (i == 15) begin
                @(negedge clk);
                check("ovf_drop", 32'(drop), 32'd1);
                check("ovf_level", 32'(level), 32'd0);
                tick();
            end
        end
        @(negedge clk);
        check("ovf_level_end", 32'(level), 32'd0);
        check("ovf_tready", 32'(s_if.tready), 32'd1);
        tick();
        send_beat(8'h5A, 1'b0, 1'b0);
        send_beat(8'h5B, 1'b1, 1'b0);
        drain();
`endif

        // Randomised traffic, packets of 1..8 beats
        plen = $urandom_range(1, 8);
        pcnt = 0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            acc = ena && s_if.tvalid && s_if.tready;
            tick();
            if (acc) begin
                if (s_if.tlast) begin
                    pcnt = 0;
                    plen = $urandom_range(1, 8);
                end else begin
                    pcnt++;
                end
            end
            if (!s_if.tvalid || acc) begin
                s_if.tvalid = ($urandom_range(0, 9) < 6);
                s_if.tdata  = 8'($urandom);
                s_if.tlast  = (pcnt + 1 >= plen);
                s_if.tuser  = s_if.tlast && ($urandom_range(0, 4) == 0);
            end
            ena         = ($urandom_range(0, 9) != 0);
            m_if.tready = ($urandom_range(0, 9) < 7);
        end
        ena = 1'b1;
        @(negedge clk);
        acc = s_if.tvalid && s_if.tready;
        tick();
        if (acc) begin
            if (s_if.tlast) pcnt = 0;
            else pcnt++;
        end
        s_if.tvalid = 1'b0;
        if (pcnt != 0) send_beat(8'hFF, 1'b1, 1'b0);
        drain();
        @(negedge clk);
        check("final_queue", 32'(exp_q.size()), 32'd0);
        check("final_level", 32'(level), 32'd0);
        check("drop_count", 32'(seen_drops), 32'(exp_drops));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
